// File: rtl/easyaxi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : easyaxi_pkg
//  Brief    : Shared types and constants for the EasyAXI read arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package easyaxi_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int c_default_addr_width = 32;
    localparam int c_default_data_width = 32;
    localparam int c_default_id_width   = 4;
    localparam int c_default_ost_max    = 8;

    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [1:0] c_burst_wrap  = 2'b10;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

endpackage
`default_nettype wire

// File: rtl/easyaxi_rd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : easyaxi_rd_arb_if
//  Brief    : EasyAXI read port (AR + R channels) with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface easyaxi_rd_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface
`default_nettype wire

// File: rtl/easyaxi_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : easyaxi_rr_arb2
//  Brief    : Combinational two-request round-robin picker.
//  Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    // Priority pointer only matters on contention; otherwise take the lone requester.
    assign gnt_idx   = (req == 2'b11) ? rr_ptr : req[1];

endmodule
`default_nettype wire

// File: rtl/easyaxi_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : easyaxi_rd_arb
//  Brief    : Two-master EasyAXI read arbiter: round-robin AR, ID-steered R.
//  Revision : 1.0 - initial release
// ============================================================================
module easyaxi_rd_arb
    import easyaxi_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ID_WIDTH   = c_default_id_width,
    parameter int OST_MAX    = c_default_ost_max
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    easyaxi_rd_arb_if.slave  m0,
    easyaxi_rd_arb_if.slave  m1,
    easyaxi_rd_arb_if.master s
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic                  r_gnt;
    logic                  w_gnt_nxt;
    logic                  r_rr_ptr;
    logic                  w_rr_ptr_nxt;
    logic [1:0][3:0]       r_ost_cnt;

    logic [1:0]            w_arvalid;
    logic [1:0]            w_elig;
    logic [1:0]            w_inc;
    logic [1:0]            w_dec;
    logic                  w_pick_valid;
    logic                  w_pick_idx;
    logic                  w_lock;
    logic                  w_ar_hs;
    logic                  w_r_sel;
    logic                  w_r_last_hs;
    logic [ID_WIDTH-1:0]   w_arid;
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_arvalid = {m1.arvalid, m0.arvalid};
    assign w_elig[0] = w_arvalid[0] & (r_ost_cnt[0] < 4'(OST_MAX));
    assign w_elig[1] = w_arvalid[1] & (r_ost_cnt[1] < 4'(OST_MAX));

    easyaxi_rr_arb2 u_rr_arb2 (
        .req       (w_elig),
        .rr_ptr    (r_rr_ptr),
        .gnt_valid (w_pick_valid),
        .gnt_idx   (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_gnt    <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Once locked the grant is held until the handshake, regardless of enable.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (enable && w_pick_valid) begin
                    w_state_nxt = ARB_LOCK;
                    w_gnt_nxt   = w_pick_idx;
                end
            end
            ARB_LOCK: begin
                if (w_ar_hs) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = ~r_gnt;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // AR mux select is the registered grant only, keeping the payload stable.
    assign w_lock    = (r_state == ARB_LOCK);
    assign w_arid    = r_gnt ? m1.arid   : m0.arid;
    assign w_araddr  = r_gnt ? m1.araddr : m0.araddr;
    assign s.arvalid = w_lock & w_arvalid[r_gnt];
    assign s.arid    = {r_gnt, w_arid};
    assign s.araddr  = w_araddr;
    assign s.arlen   = r_gnt ? m1.arlen   : m0.arlen;
    assign s.arsize  = r_gnt ? m1.arsize  : m0.arsize;
    assign s.arburst = r_gnt ? m1.arburst : m0.arburst;
    assign m0.arready = w_lock & ~r_gnt & s.arready;
    assign m1.arready = w_lock &  r_gnt & s.arready;
    assign w_ar_hs    = s.arvalid & s.arready;

    // R path: the ID's top bit names the originating master.
    assign w_r_sel   = s.rid[ID_WIDTH];
    assign w_rdata   = s.rdata;
    assign m0.rvalid = s.rvalid & ~w_r_sel;
    assign m1.rvalid = s.rvalid &  w_r_sel;
    assign m0.rid    = s.rid[ID_WIDTH-1:0];
    assign m1.rid    = s.rid[ID_WIDTH-1:0];
    assign m0.rdata  = w_rdata;
    assign m1.rdata  = w_rdata;
    assign m0.rresp  = s.rresp;
    assign m1.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m1.rlast  = s.rlast;
    assign s.rready  = w_r_sel ? m1.rready : m0.rready;
    assign w_r_last_hs = s.rvalid & s.rready & s.rlast;

    assign w_inc = {w_ar_hs &  r_gnt, w_ar_hs & ~r_gnt};
    assign w_dec = {w_r_last_hs & w_r_sel, w_r_last_hs & ~w_r_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ost_cnt <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_inc[n] && !w_dec[n]) begin
                    r_ost_cnt[n] <= r_ost_cnt[n] + 4'd1;
                end else if (w_dec[n] && !w_inc[n] && (r_ost_cnt[n] != 4'd0)) begin
                    r_ost_cnt[n] <= r_ost_cnt[n] - 4'd1;
                end
            end
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_dec[n] && !w_inc[n] && (r_ost_cnt[n] == 4'd0)));
    end

endmodule
`default_nettype wire
